rtc_timekeeper: RTL and testbench

Parametrised time-of-day counter that generalises the seconds/minutes clock into a full hours:minutes:seconds timekeeper. It has a built-in clock prescaler, run/pause control, a validated synchronous time load, a minute-resolution alarm, rollover strobes and a 12-hour display view. It sits between the system clock domain and display/alarm logic, and supplies one-cycle strobes to downstream event counters.

---
 rtl/rtc_timekeeper.sv | 142 ++++++++++++++
 tb/tb_rtc_timekeeper.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timekeeper.sv
// Hours:minutes:seconds timekeeper with prescaler, run/pause, validated load,
// minute-resolution alarm, rollover strobes and a 12-hour display view.
module rtc_timekeeper #(
   parameter int CLK_DIV = 1,
   parameter int DIV_W   = $clog2(CLK_DIV > 1 ? CLK_DIV : 2)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       load,
   input  logic [4:0] load_hr,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       alarm_en,
   input  logic [4:0] alarm_hr,
   input  logic [5:0] alarm_min,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [3:0] hours12,
   output logic       pm,
   output logic       tick,
   output logic       min_roll,
   output logic       day_roll,
   output logic       alarm,
   output logic       load_err
);

   localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_presc;
   logic [4:0]       r_hours;
   logic [5:0]       r_minutes;
   logic [5:0]       r_seconds;
   logic             r_tick;
   logic             r_min_roll;
   logic             r_day_roll;
   logic             r_alarm;
   logic             r_load_err;

   logic [DIV_W-1:0] w_presc_nxt;
   logic             w_term;
   logic             w_load_ok;
   logic             w_sec_wrap;
   logic             w_min_wrap;
   logic             w_hr_wrap;
   logic [4:0]       w_nxt_hr;
   logic [5:0]       w_nxt_min;
   logic [5:0]       w_nxt_sec;
   logic             w_alarm_hit;
   logic [3:0]       w_hours12;

   // With CLK_DIV=1 the prescaler is pinned at 0, so every run cycle is terminal.
   assign w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
   assign w_term      = run && (r_presc == PRESC_MAX);
   assign w_load_ok   = (load_hr <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);

   assign w_sec_wrap = (r_seconds == 6'd59);
   assign w_min_wrap = w_sec_wrap && (r_minutes == 6'd59);
   assign w_hr_wrap  = w_min_wrap && (r_hours == 5'd23);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first; a
      // path that leaves one unassigned would otherwise infer a latch.
      w_nxt_sec = r_seconds + 6'd1;
      w_nxt_min = r_minutes;
      w_nxt_hr  = r_hours;
      if (w_sec_wrap) begin
         w_nxt_sec = 6'd0;
         w_nxt_min = r_minutes + 6'd1;
         if (w_min_wrap) begin
            w_nxt_min = 6'd0;
            w_nxt_hr  = w_hr_wrap ? 5'd0 : r_hours + 5'd1;
         end
      end
   end

   // New seconds are 0 exactly when they wrap; an out-of-range alarm can never
   // equal a legal time, so no explicit range check is needed here.
   assign w_alarm_hit = alarm_en && w_sec_wrap &&
                        (w_nxt_hr == alarm_hr) && (w_nxt_min == alarm_min);

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         r_presc    <= '0;
         r_hours    <= 5'd0;
         r_minutes  <= 6'd0;
         r_seconds  <= 6'd0;
         r_tick     <= 1'b0;
         r_min_roll <= 1'b0;
         r_day_roll <= 1'b0;
         r_alarm    <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_tick     <= 1'b0;
         r_min_roll <= 1'b0;
         r_day_roll <= 1'b0;
         r_alarm    <= 1'b0;
         r_load_err <= 1'b0;
         if (load && w_load_ok) begin
            r_hours   <= load_hr;
            r_minutes <= load_min;
            r_seconds <= load_sec;
            r_presc   <= '0;
         end else begin
            r_load_err <= load;
            if (run) r_presc <= w_presc_nxt;
            // A rejected load still claims the edge: the prescaler keeps counting
            // but the time does not advance.
            if (w_term && !load) begin
               r_seconds  <= w_nxt_sec;
               r_minutes  <= w_nxt_min;
               r_hours    <= w_nxt_hr;
               r_tick     <= 1'b1;
               r_min_roll <= w_sec_wrap;
               r_day_roll <= w_hr_wrap;
               r_alarm    <= w_alarm_hit;
            end
         end
      end
   end

   always_comb begin
      w_hours12 = r_hours[3:0];
      if (r_hours == 5'd0)      w_hours12 = 4'd12;
      else if (r_hours > 5'd12) w_hours12 = 4'(r_hours - 5'd12);
   end

   assign hours    = r_hours;
   assign minutes  = r_minutes;
   assign seconds  = r_seconds;
   assign hours12  = w_hours12;
   assign pm       = (r_hours >= 5'd12);
   assign tick     = r_tick;
   assign min_roll = r_min_roll;
   assign day_roll = r_day_roll;
   assign alarm    = r_alarm;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper: a seconds-of-day reference model feeds an
// expectation queue that a free-running monitor drains every cycle.
module tb_rtc_timekeeper;

   localparam int CLK_DIV = 4;
   localparam int DAY     = 86400;

   logic       clk = 1'b0;
   logic       reset, run, load, alarm_en;
   logic [4:0] load_hr, alarm_hr;
   logic [5:0] load_min, load_sec, alarm_min;
   logic [4:0] hours;
   logic [5:0] minutes, seconds;
   logic [3:0] hours12;
   logic       pm, tick, min_roll, day_roll, alarm, load_err;

   rtc_timekeeper #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .reset(reset), .run(run), .load(load),
      .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
      .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
      .hours(hours), .minutes(minutes), .seconds(seconds),
      .hours12(hours12), .pm(pm), .tick(tick), .min_roll(min_roll),
      .day_roll(day_roll), .alarm(alarm), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] hr;
      logic [5:0] mn;
      logic [5:0] sc;
      logic [3:0] h12;
      logic       pm;
      logic       tick;
      logic       mroll;
      logic       droll;
      logic       alarm;
      logic       lerr;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   bit   started = 1'b0;

   // Reference model state: time as seconds since midnight, plus prescaler count.
   int   m_t     = 0;
   int   m_presc = 0;
   bit   cur_aen = 1'b0;
   int   cur_ah  = 0;
   int   cur_am  = 0;

   task automatic step(input bit rst, input bit r, input bit ld,
                       input int lh, input int lm, input int ls);
      obs_t e;
      bit   term;
      int   h;
      int   ah, am;
      @(negedge clk);
      reset     = rst;
      run       = r;
      load      = ld;
      load_hr   = 5'(lh);
      load_min  = 6'(lm);
      load_sec  = 6'(ls);
      alarm_en  = cur_aen;
      alarm_hr  = 5'(cur_ah);
      alarm_min = 6'(cur_am);
      ah = int'(alarm_hr);
      am = int'(alarm_min);
      e  = '0;
      if (rst) begin
         m_t     = 0;
         m_presc = 0;
      end else if (ld && int'(load_hr) < 24 && int'(load_min) < 60 && int'(load_sec) < 60) begin
         m_t     = int'(load_hr) * 3600 + int'(load_min) * 60 + int'(load_sec);
         m_presc = 0;
      end else begin
         term   = r && (m_presc == CLK_DIV - 1);
         e.lerr = ld;
         if (r) m_presc = (m_presc + 1) % CLK_DIV;
         if (term && !ld) begin
            m_t     = (m_t + 1) % DAY;
            e.tick  = 1'b1;
            e.mroll = (m_t % 60 == 0);
            e.droll = (m_t == 0);
            e.alarm = cur_aen && ah < 24 && am < 60 && (m_t == ah * 3600 + am * 60);
         end
      end
      h     = m_t / 3600;
      e.hr  = 5'(h);
      e.mn  = 6'((m_t / 60) % 60);
      e.sc  = 6'(m_t % 60);
      e.h12 = 4'((h % 12 == 0) ? 12 : h % 12);
      e.pm  = (h >= 12);
      exp_q.push_back(e);
      started = 1'b1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(1'b0, r, 1'b0, 0, 0, 0);
   endtask

   task automatic do_load(input int lh, input int lm, input int ls);
      step(1'b0, 1'b0, 1'b1, lh, lm, ls);
   endtask

   task automatic run_to_terminal();
      for (int i = 0; i < CLK_DIV && m_presc != CLK_DIV - 1; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 0);
   endtask

   obs_t mon_a, mon_e;
   always @(posedge clk) begin
      #1;
      if (started) begin
         mon_a = {hours, minutes, seconds, hours12, pm, tick, min_roll, day_roll, alarm, load_err};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow at %0t: no expectation queued", $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a !== mon_e) begin
               n_bad++;
               $display("FAIL cycle_state at %0t: got %0d:%0d:%0d h12=%0d pm=%0d tk=%0d mr=%0d dr=%0d al=%0d le=%0d, want %0d:%0d:%0d h12=%0d pm=%0d tk=%0d mr=%0d dr=%0d al=%0d le=%0d",
                        $time, mon_a.hr, mon_a.mn, mon_a.sc, mon_a.h12, mon_a.pm, mon_a.tick,
                        mon_a.mroll, mon_a.droll, mon_a.alarm, mon_a.lerr,
                        mon_e.hr, mon_e.mn, mon_e.sc, mon_e.h12, mon_e.pm, mon_e.tick,
                        mon_e.mroll, mon_e.droll, mon_e.alarm, mon_e.lerr);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int h, s;
      reset = 1'b1; run = 1'b0; load = 1'b0; alarm_en = 1'b0;
      load_hr = '0; load_min = '0; load_sec = '0; alarm_hr = '0; alarm_min = '0;

      // Reset, then basic count: 16 run cycles give four ticks.
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b0, 0, 0, 0);
      idle(16, 1'b1);

      // Day wrap from 23:59:58.
      do_load(23, 59, 58);
      idle(2 * CLK_DIV, 1'b1);

      // Load validation: two rejected loads, then a good one.
      do_load(24, 0, 0);
      do_load(12, 60, 0);
      do_load(13, 5, 7);
      idle(2, 1'b0);

      // Alarm at 07:30, then reload onto it, then disarmed.
      cur_aen = 1'b1; cur_ah = 7; cur_am = 30;
      do_load(7, 29, 59);
      idle(CLK_DIV + 1, 1'b1);
      do_load(7, 30, 0);
      idle(2, 1'b1);
      cur_aen = 1'b0;
      do_load(7, 29, 59);
      idle(CLK_DIV + 1, 1'b1);

      // Back-to-back loads, last valid one wins.
      step(1'b0, 1'b1, 1'b1, 1, 2, 3);
      step(1'b0, 1'b1, 1'b1, 4, 5, 6);
      step(1'b0, 1'b1, 1'b1, 31, 5, 6);

      // Pause mid-count, then a load on a terminal-count cycle.
      idle(2, 1'b1);
      idle(10, 1'b0);
      run_to_terminal();
      step(1'b0, 1'b1, 1'b1, 5, 0, 0);
      idle(CLK_DIV + 1, 1'b1);

      // Reset on a terminal count at 10:59:59.
      do_load(10, 59, 59);
      run_to_terminal();
      step(1'b1, 1'b1, 1'b0, 0, 0, 0);
      idle(3, 1'b1);

      // Randomized traffic biased toward rollovers and alarm hits.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            step(1'b1, 1'b1, 1'b0, 0, 0, 0);
         end else if ($urandom_range(0, 24) == 0) begin
            if ($urandom_range(0, 1) == 0) begin
               step(1'b0, $urandom_range(0, 3) != 0, 1'b1,
                    $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            end else begin
               h = $urandom_range(0, 23);
               s = $urandom_range(50, 59);
               if ($urandom_range(0, 1) == 0) begin
                  cur_aen = $urandom_range(0, 3) != 0;
                  cur_ah  = (h + 1) % 24;
                  cur_am  = 0;
               end
               step(1'b0, $urandom_range(0, 3) != 0, 1'b1, h, 59, s);
            end
         end else begin
            if ($urandom_range(0, 299) == 0) begin
               cur_aen = $urandom_range(0, 1);
               cur_ah  = $urandom_range(0, 31);
               cur_am  = $urandom_range(0, 63);
            end
            step(1'b0, $urandom_range(0, 9) != 0, 1'b0, 0, 0, 0);
         end
      end

      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
